// File: rtl/ifetch_unit_if.sv
// Bundle of the fetch unit's memory-side and decoder-side signals.
//   master : instruction fetch unit (drives imem_req/addr and the instruction buffer)
//   slave  : environment (instruction memory, decoder/control, redirect source)
interface ifetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] Instruction;
  logic [31:0] opcplus4;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_err;

  modport master (
    output imem_req, imem_addr, Instruction, opcplus4, inst_valid, fetch_err,
    input  imem_gnt, imem_rvalid, imem_rdata, inst_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, Instruction, opcplus4, inst_valid, fetch_err,
    output imem_gnt, imem_rvalid, imem_rdata, inst_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one word at a time from instruction
// memory over req/gnt/rvalid, buffers it for the decoder under valid/ready and applies
// control-transfer redirects.
// Ports:
//   clock, reset      : clock (rising edge) and asynchronous active-low reset
//   bus (master)      : imem_req/addr/gnt/rvalid/rdata, Instruction/opcplus4/inst_valid/
//                       inst_ready, redirect/redirect_pc, fetch_err (sticky)
// Optional feature macro IFETCH_PERF_CNT_EN adds fetch_count / kill_count outputs.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic          clock,
  input  logic          reset,
  ifetch_unit_if.master bus
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]   fetch_count,
  output logic [15:0]   kill_count
`endif
);

  localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StFull} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        kill_q, kill_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        imem_req_q, imem_req_d;
  logic [31:0] imem_addr_q, imem_addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] opcplus4_q, opcplus4_d;
  logic        inst_valid_q, inst_valid_d;
  logic        fetch_err_q, fetch_err_d;

  // A response is dropped when it was already marked unwanted or a redirect lands with it.
  logic drop_rsp;
  logic discard_buf;
  assign drop_rsp    = (state_q == StWait) && bus.imem_rvalid && (kill_q || bus.redirect);
  assign discard_buf = (state_q == StFull) && bus.redirect && !bus.inst_ready;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      pend_pc_q    <= RESET_PC;
      kill_q       <= 1'b0;
      wait_cnt_q   <= 8'd0;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= RESET_PC;
      instr_q      <= 32'd0;
      opcplus4_q   <= 32'd0;
      inst_valid_q <= 1'b0;
      fetch_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_pc_q    <= pend_pc_d;
      kill_q       <= kill_d;
      wait_cnt_q   <= wait_cnt_d;
      imem_req_q   <= imem_req_d;
      imem_addr_q  <= imem_addr_d;
      instr_q      <= instr_d;
      opcplus4_q   <= opcplus4_d;
      inst_valid_q <= inst_valid_d;
      fetch_err_q  <= fetch_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: state_d = StReq;
      StReq:  if (bus.imem_gnt) state_d = StWait;
      StWait: if (bus.imem_rvalid) state_d = (kill_q || bus.redirect) ? StReq : StFull;
      StFull: if (bus.redirect || bus.inst_ready) state_d = StReq;
      default: state_d = StIdle;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    pc_d         = pc_q;
    pend_pc_d    = pend_pc_q;
    kill_d       = kill_q;
    wait_cnt_d   = wait_cnt_q;
    instr_d      = instr_q;
    opcplus4_d   = opcplus4_q;
    inst_valid_d = inst_valid_q;
    fetch_err_d  = fetch_err_q;

    unique case (state_q)
      StReq: begin
        if (bus.imem_gnt) begin
          pend_pc_d  = pc_q;
          pc_d       = pc_q + 32'd4;
          wait_cnt_d = 8'd0;
          // Granted access is still outstanding; its data must be thrown away.
          if (bus.redirect) kill_d = 1'b1;
        end
      end
      StWait: begin
        if (wait_cnt_q != MaxWait) wait_cnt_d = wait_cnt_q + 8'd1;
        if (bus.imem_rvalid) begin
          if (kill_q || bus.redirect) begin
            kill_d = 1'b0;
          end else begin
            instr_d      = bus.imem_rdata;
            opcplus4_d   = pend_pc_q + 32'd4;
            inst_valid_d = 1'b1;
          end
        end else begin
          // Timeout is reported but the fetch is not reissued.
          if (wait_cnt_q == MaxWait) fetch_err_d = 1'b1;
          if (bus.redirect) kill_d = 1'b1;
        end
      end
      StFull: begin
        if (bus.redirect || bus.inst_ready) inst_valid_d = 1'b0;
      end
      default: ;
    endcase

    // Redirect overrides the sequential pc+4 update.
    if (bus.redirect) begin
      pc_d = bus.redirect_pc & ~32'h3;
      if (bus.redirect_pc[1:0] != 2'b00) fetch_err_d = 1'b1;
    end
  end

  // Output logic
  always_comb begin
    imem_req_d  = (state_d == StReq);
    imem_addr_d = pc_d;
  end

  assign bus.imem_req    = imem_req_q;
  assign bus.imem_addr   = imem_addr_q;
  assign bus.Instruction = instr_q;
  assign bus.opcplus4    = opcplus4_q;
  assign bus.inst_valid  = inst_valid_q;
  assign bus.fetch_err   = fetch_err_q;

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [15:0] kill_count_q, kill_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q;
    kill_count_d  = kill_count_q;
    if (inst_valid_q && bus.inst_ready) fetch_count_d = fetch_count_q + 32'd1;
    if ((drop_rsp || discard_buf) && (kill_count_q != 16'hFFFF)) begin
      kill_count_d = kill_count_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_count_q <= 32'd0;
      kill_count_q  <= 16'd0;
    end else begin
      fetch_count_q <= fetch_count_d;
      kill_count_q  <= kill_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
  assign kill_count  = kill_count_q;
`else
  logic unused_perf;
  assign unused_perf = drop_rsp ^ discard_buf;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized bench for ifetch_unit. A memory model grants and answers requests with
// address-derived data; a transaction-level model tracks the expected fetch address
// stream, the instruction(s) that must reach the decoder, and the sticky error flag.
module tb_ifetch_unit;
  localparam logic [31:0] ResetPc = 32'h0000_0000;
  localparam int unsigned MaxWait = 15;

  logic clock;
  logic reset;
  ifetch_unit_if bus ();

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [15:0] kill_count;
`endif

  ifetch_unit #(
    .RESET_PC (ResetPc),
    .MAX_WAIT (MaxWait)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .fetch_count (fetch_count),
    .kill_count  (kill_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned n_vec;
  int unsigned n_err;

  // Stimulus knobs
  int unsigned gnt_pct, ready_pct, redir_pct, dly_min, dly_max;
  logic        force_redir;
  logic [31:0] force_tgt;

  // Memory model
  logic        mem_busy, mem_killed;
  logic [31:0] mem_addr;
  int unsigned mem_rem, mem_age;

  // Reference model
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;
  logic        exp_err;
  logic [31:0] fetch_mdl;
  logic [15:0] kill_mdl;
  int unsigned n_deliv, n_grant;
  logic [31:0] last_grant;
  logic [31:0] grant_log[$];
  logic [31:0] dlv_ins[$];
  logic [31:0] dlv_op[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] data_for(input logic [31:0] a);
    if (a == 32'd0) return 32'h2008_0005;
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_3C3C;
  endfunction

  function automatic logic [31:0] rand_target();
    int unsigned r;
    r = $urandom_range(99);
    if (r < 5) return 32'hFFFF_FFFC;
    if (r < 9) return ($urandom & 32'h0000_0FFC) | 32'($urandom_range(3, 1));
    return $urandom & 32'h0000_FFFC;
  endfunction

  // One clock cycle: check outputs, drive inputs, advance the model.
  task automatic step();
    logic        fire, g, rdy, rd, acc;
    logic [31:0] tgt, a;
    @(negedge clock);
    check_val("inst_valid", 32'(bus.inst_valid), 32'(exp_q.size() != 0));
    check_val("fetch_err", 32'(bus.fetch_err), 32'(exp_err));
    if (bus.inst_valid) check_val("req_in_full", 32'(bus.imem_req), 32'd0);

    fire = 1'b0;
    if (mem_busy) begin
      mem_age++;
      mem_rem--;
      if (mem_rem == 0) begin
        fire     = 1'b1;
        mem_busy = 1'b0;
      end
    end
    g   = bus.imem_req && !mem_busy && ($urandom_range(99) < gnt_pct);
    rdy = ($urandom_range(99) < ready_pct);
    rd  = force_redir || ($urandom_range(99) < redir_pct);
    tgt = force_redir ? force_tgt : rand_target();
    force_redir = 1'b0;

    bus.imem_gnt    = g;
    bus.imem_rvalid = fire;
    bus.imem_rdata  = fire ? data_for(mem_addr) : $urandom;
    bus.inst_ready  = rdy;
    bus.redirect    = rd;
    bus.redirect_pc = rd ? tgt : $urandom;

    acc = bus.inst_valid && rdy;
    if (acc && exp_q.size() != 0) begin
      a = exp_q.pop_front();
      check_val("instr", bus.Instruction, data_for(a));
      check_val("opcplus4", bus.opcplus4, a + 32'd4);
      dlv_ins.push_back(bus.Instruction);
      dlv_op.push_back(bus.opcplus4);
      n_deliv++;
      fetch_mdl++;
    end
    if (fire) begin
      if (mem_killed || rd) begin
        if (kill_mdl != 16'hFFFF) kill_mdl++;
      end else begin
        exp_q.push_back(mem_addr);
      end
    end
    if (mem_busy && mem_age == MaxWait + 1) exp_err = 1'b1;
    if (g) begin
      check_val("grant_addr", bus.imem_addr, exp_pc);
      last_grant = bus.imem_addr;
      grant_log.push_back(bus.imem_addr);
      n_grant++;
      mem_addr   = bus.imem_addr;
      mem_busy   = 1'b1;
      mem_killed = 1'b0;
      mem_age    = 0;
      mem_rem    = $urandom_range(dly_max, dly_min);
      exp_pc     = exp_pc + 32'd4;
    end
    if (rd) begin
      exp_pc = tgt & ~32'h3;
      if (tgt[1:0] != 2'b00) exp_err = 1'b1;
      if (mem_busy) mem_killed = 1'b1;
      if (exp_q.size() != 0 && !acc && kill_mdl != 16'hFFFF) kill_mdl++;
      exp_q.delete();
    end
  endtask

  // Reset; a response still outstanding is presented in the first cycle after release.
  task automatic do_reset();
    logic stale;
    @(negedge clock);
    reset           = 1'b0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.inst_ready  = 1'b0;
    bus.redirect    = 1'b0;
    stale           = mem_busy;
    mem_busy        = 1'b0;
    exp_q.delete();
    exp_pc    = ResetPc;
    exp_err   = 1'b0;
    fetch_mdl = 32'd0;
    kill_mdl  = 16'd0;
    @(negedge clock);
    check_val("rst_req", 32'(bus.imem_req), 32'd0);
    check_val("rst_addr", bus.imem_addr, ResetPc);
    check_val("rst_instr", bus.Instruction, 32'd0);
    check_val("rst_op", bus.opcplus4, 32'd0);
    check_val("rst_valid", 32'(bus.inst_valid), 32'd0);
    check_val("rst_err", 32'(bus.fetch_err), 32'd0);
    reset           = 1'b1;
    bus.imem_rvalid = stale;
    bus.imem_rdata  = 32'hDEAD_BEEF;
  endtask

  task automatic run_until_deliv(input int unsigned n, input int unsigned budget);
    int unsigned start, i;
    start = n_deliv;
    i = 0;
    while (n_deliv - start < n && i < budget) begin
      step();
      i++;
    end
    check_val("deliv_timeout", 32'(n_deliv - start >= n), 32'd1);
  endtask

  task automatic run_until_grant(input int unsigned budget);
    int unsigned start, i;
    start = n_grant;
    i = 0;
    while (n_grant == start && i < budget) begin
      step();
      i++;
    end
    check_val("grant_timeout", 32'(n_grant != start), 32'd1);
  endtask

  initial begin
    int unsigned base, gbase, dbase, i;
    n_vec = 0; n_err = 0;
    reset = 1'b0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'd0;
    bus.inst_ready = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'd0;
    mem_busy = 1'b0; mem_killed = 1'b0; mem_addr = 32'd0; mem_rem = 0; mem_age = 0;
    force_redir = 1'b0; force_tgt = 32'd0;
    n_deliv = 0; n_grant = 0; last_grant = 32'd0;
    gnt_pct = 100; ready_pct = 100; redir_pct = 0; dly_min = 1; dly_max = 1;

    // Immediate grant, 1-cycle response
    do_reset();
    gbase = grant_log.size();
    dbase = dlv_ins.size();
    run_until_deliv(2, 50);
    check_val("first_addr", grant_log[gbase], 32'h0);
    check_val("second_addr", grant_log[gbase+1], 32'h4);
    check_val("first_instr", dlv_ins[dbase], 32'h2008_0005);
    check_val("first_op", dlv_op[dbase], 32'h4);

    // Stall in FULL for 5 cycles
    ready_pct = 0;
    i = 0;
    while (!bus.inst_valid && i < 20) begin step(); i++; end
    check_val("stall_reach", 32'(bus.inst_valid), 32'd1);
    for (int k = 0; k < 5; k++) step();
    check_val("stall_valid", 32'(bus.inst_valid), 32'd1);
    if (exp_q.size() != 0) check_val("stall_instr", bus.Instruction, data_for(exp_q[0]));
    ready_pct = 100;
    run_until_deliv(2, 50);

    // Redirect while waiting; response arrives 2 cycles later and is dropped
    dly_min = 3; dly_max = 3;
    i = 0;
    while (!(mem_busy && mem_age == 0) && i < 30) begin step(); i++; end
    check_val("wait_reach", 32'(mem_busy), 32'd1);
    force_redir = 1'b1; force_tgt = 32'h0000_0040;
    base = n_deliv;
    step();
    run_until_grant(30);
    check_val("redir_addr", last_grant, 32'h40);
    check_val("redir_drop", n_deliv - base, 32'd0);

    // Misaligned redirect
    dly_min = 1; dly_max = 1;
    force_redir = 1'b1; force_tgt = 32'h0000_0102;
    step();
    run_until_grant(30);
    check_val("misal_addr", last_grant, 32'h100);
    check_val("misal_err", 32'(bus.fetch_err), 32'd1);
    run_until_deliv(1, 30);

    // Timeout boundary: 16-cycle response is in time, 17 is not
    do_reset();
    dly_min = 16; dly_max = 16;
    run_until_deliv(1, 60);
    check_val("no_timeout", 32'(bus.fetch_err), 32'd0);
    dly_min = 17; dly_max = 17;
    run_until_deliv(1, 60);
    step();
    check_val("timeout_err", 32'(bus.fetch_err), 32'd1);

    // Reset while a response is outstanding
    dly_min = 5; dly_max = 5;
    i = 0;
    while (!mem_busy && i < 30) begin step(); i++; end
    check_val("busy_reach", 32'(mem_busy), 32'd1);
    do_reset();
    dly_min = 1; dly_max = 1;
    dbase = dlv_ins.size();
    run_until_deliv(1, 30);
    check_val("post_rst_op", dlv_op[dbase], ResetPc + 32'd4);
    check_val("post_rst_instr", dlv_ins[dbase], 32'h2008_0005);

    // Random traffic
    do_reset();
    gnt_pct = 60; ready_pct = 70; redir_pct = 8; dly_min = 1; dly_max = 6;
    base = n_deliv;
    for (int k = 0; k < 3000; k++) step();
    check_val("liveness", 32'(n_deliv - base >= 100), 32'd1);

`ifdef IFETCH_PERF_CNT_EN
    @(negedge clock);
    check_val("fetch_count", fetch_count, fetch_mdl);
    check_val("kill_count", 32'(kill_count), 32'(kill_mdl));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
